// File: rtl/ram_sync_sp_if.sv
// Access bus of the synchronous single-port RAM: request, write data, registered read result and status.
// Handshake: a request (cs=1; we selects write/read) is accepted on a rising edge only while ready=1;
// an accepted read returns rd_data one cycle later with rd_valid high for exactly that cycle.
interface ram_sync_sp_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 12
);
  logic                  cs;
  logic                  we;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  ready;
  logic                  parity_err;
  logic                  dbg_run;  // controller state: 0 = clear sweep, 1 = run

  modport master (
    output cs, we, address, wr_data,
    input  rd_data, rd_valid, ready, parity_err, dbg_run
  );

  modport slave (
    input  cs, we, address, wr_data,
    output rd_data, rd_valid, ready, parity_err, dbg_run
  );
endinterface

// File: rtl/ram_sync_sp.sv
// Synchronous single-port RAM with registered read, one-cycle valid strobe and optional post-reset clear sweep.
// Define RAM_PARITY_EN to store an even-parity bit per word and report mismatches on read via parity_err.
module ram_sync_sp #(
  parameter int                    DATA_WIDTH     = 4,
  parameter int                    ADDR_WIDTH     = 12,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL      = '0
) (
  input logic          clk,
  input logic          reset,
  ram_sync_sp_if.slave bus
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
`ifdef RAM_PARITY_EN
  localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
  localparam int MEM_WIDTH = DATA_WIDTH;
`endif

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam state_e RESET_STATE = state_e'(CLEAR_ON_RESET ? ST_CLEAR : ST_RUN);

  logic [MEM_WIDTH-1:0]  mem_q [RAM_DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  ready_q, ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MEM_WIDTH-1:0]  mem_word;
  logic [MEM_WIDTH-1:0]  rd_word;

  assign rd_word = mem_q[bus.address];

`ifdef RAM_PARITY_EN
  assign mem_word = {^mem_wdata, mem_wdata};
`else
  assign mem_word = mem_wdata;
`endif

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    ready_d      = ready_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    parity_err_d = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = bus.address;
    mem_wdata    = bus.wr_data;
    unique case (state_q)
      ST_CLEAR: begin
        // Bus inputs are ignored; the sweep owns the write port until the last word is cleared.
        mem_we     = 1'b1;
        mem_addr   = clr_addr_q;
        mem_wdata  = CLEAR_VAL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
        if (bus.cs && ready_q) begin
          if (bus.we) begin
            mem_we = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_word[DATA_WIDTH-1:0];
`ifdef RAM_PARITY_EN
            parity_err_d = (^rd_word[DATA_WIDTH-1:0]) != rd_word[DATA_WIDTH];
`endif
          end
        end
      end
      default: ;
    endcase
    // Reset wins over any request presented in the same cycle.
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RESET_STATE;
      clr_addr_q   <= '0;
      ready_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      ready_q      <= ready_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Storage is deliberately not reset; only the sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_addr] <= mem_word;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.ready      = ready_q;
  assign bus.parity_err = parity_err_q;
  assign bus.dbg_run    = (state_q == ST_RUN);
endmodule

// File: tb/tb_ram_sync_sp.sv
// Directed plus randomized bench for ram_sync_sp: clear sweep timing, read/write behaviour,
// reset interactions and the no-sweep configuration, checked against an array-based reference model.
module tb_ram_sync_sp;
  localparam int             DW    = 4;
  localparam int             AW    = 4;
  localparam int             DEPTH = 16;
  localparam logic [DW-1:0]  CLR   = 4'h9;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic [DW-1:0] last_rd;

  ram_sync_sp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if0 ();
  ram_sync_sp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  ram_sync_sp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(CLR)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );

  ram_sync_sp #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(CLR)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  // clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One accepted-cycle operation on dut0 in RUN, checked against the reference array.
  task automatic op0(input logic cs, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic exp_valid;
    if0.cs = cs; if0.we = we; if0.address = a; if0.wr_data = d;
    exp_valid = cs && !we;
    if (exp_valid) exp_q.push_back(model_mem[a]);
    if (cs && we) model_mem[a] = d;
    tick();
    check("rd_valid", if0.rd_valid, exp_valid);
    if (exp_valid) last_rd = exp_q.pop_front();
    check("rd_data", if0.rd_data, last_rd);
    check("parity_err", if0.parity_err, 0);
    check("ready_run", if0.ready, 1);
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    check("rst_ready", if0.ready, 0);
    check("rst_rd_valid", if0.rd_valid, 0);
    check("rst_rd_data", if0.rd_data, 0);
    check("rst_parity", if0.parity_err, 0);
    check("rst_state", if0.dbg_run, 0);
    reset = 1'b0;
    last_rd = '0;
  endtask

  // Sweep in progress: hammer random writes that must be discarded; ready rises after DEPTH edges.
  task automatic sweep_check(input string tag);
    for (int i = 0; i <= DEPTH; i++) begin
      check(tag, if0.ready, (i == DEPTH));
      check("sweep_state", if0.dbg_run, (i == DEPTH));
      check("sweep_rd_valid", if0.rd_valid, 0);
      if (i < DEPTH) begin
        if0.cs = 1'b1; if0.we = 1'b1;
        if0.address = AW'($urandom_range(0, DEPTH - 1));
        if0.wr_data = DW'($urandom_range(0, 15));
        tick();
      end
    end
    if0.cs = 1'b0;
    for (int a = 0; a < DEPTH; a++) model_mem[a] = CLR;
  endtask

  initial begin
    reset = 1'b1;
    if0.cs = 1'b0; if0.we = 1'b0; if0.address = '0; if0.wr_data = '0;
    if1.cs = 1'b0; if1.we = 1'b0; if1.address = '0; if1.wr_data = '0;
    last_rd = '0;

    // reset for 2 cycles then full sweep; everything reads back as CLEAR_VAL
    apply_reset(2);
    sweep_check("sweep1_ready");
    for (int a = 0; a < DEPTH; a++) op0(1'b1, 1'b0, AW'(a), '0);
    op0(1'b0, 1'b0, '0, '0);

    // write then immediate read of the same address
    op0(1'b1, 1'b1, 4'h5, 4'hA);
    op0(1'b1, 1'b0, 4'h5, '0);

    // back-to-back reads
    op0(1'b1, 1'b1, 4'h1, 4'h1);
    op0(1'b1, 1'b1, 4'h2, 4'h2);
    op0(1'b1, 1'b1, 4'h3, 4'h3);
    op0(1'b1, 1'b0, 4'h1, '0);
    op0(1'b1, 1'b0, 4'h2, '0);
    op0(1'b1, 1'b0, 4'h3, '0);
    op0(1'b0, 1'b1, 4'h3, 4'hF);

    // random mix
    repeat (120) op0(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, DEPTH - 1)), DW'($urandom_range(0, 15)));

`ifdef RAM_PARITY_EN
    op0(1'b1, 1'b1, 4'h7, 4'h7);
    dut0.mem_q[7] = dut0.mem_q[7] ^ 5'h10;
    if0.cs = 1'b1; if0.we = 1'b0; if0.address = 4'h7;
    tick();
    check("par_rd_valid", if0.rd_valid, 1);
    check("par_rd_data", if0.rd_data, 4'h7);
    check("par_err_set", if0.parity_err, 1);
    last_rd = 4'h7;
    op0(1'b1, 1'b0, 4'h5, '0);
`endif

    // reset during a read drops it; then reset mid-sweep restarts the sweep from 0
    op0(1'b1, 1'b1, 4'h2, 4'hC);
    op0(1'b1, 1'b0, 4'h2, '0);
    if0.cs = 1'b1; if0.we = 1'b0; if0.address = 4'h2;
    apply_reset(1);
    for (int i = 0; i < 8; i++) begin
      check("mid_sweep_ready", if0.ready, 0);
      if0.cs = 1'b1; if0.we = 1'b1;
      if0.address = AW'($urandom_range(0, DEPTH - 1));
      if0.wr_data = DW'($urandom_range(0, 15));
      tick();
    end
    apply_reset(1);
    sweep_check("sweep2_ready");
    for (int a = DEPTH - 1; a >= 0; a--) op0(1'b1, 1'b0, AW'(a), '0);

    // no-sweep instance: reset beats a same-cycle write, ready one edge after release
    if1.cs = 1'b1; if1.we = 1'b1; if1.address = 4'h6; if1.wr_data = 4'hB;
    tick();
    if1.we = 1'b0;
    tick();
    check("ns_rd_valid", if1.rd_valid, 1);
    check("ns_rd_data", if1.rd_data, 4'hB);
    reset = 1'b1;
    if1.cs = 1'b1; if1.we = 1'b1; if1.address = 4'h6; if1.wr_data = 4'h4;
    tick();
    check("ns_rst_ready", if1.ready, 0);
    check("ns_rst_rd_data", if1.rd_data, 0);
    check("ns_rst_state", if1.dbg_run, 1);
    reset = 1'b0;
    if1.cs = 1'b0;
    tick();
    check("ns_ready", if1.ready, 1);
    check("ns_idle_valid", if1.rd_valid, 0);
    if1.cs = 1'b1; if1.we = 1'b0; if1.address = 4'h6;
    tick();
    check("ns_rd_valid2", if1.rd_valid, 1);
    check("ns_rd_after_rst", if1.rd_data, 4'hB);
    check("ns_parity", if1.parity_err, 0);
    if1.cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ns_hold_valid", if1.rd_valid, 0);
      check("ns_hold_data", if1.rd_data, 4'hB);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
